// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the inter-stage pipeline registers:
//   - pipe_state_e     : occupancy state of a stage register
//   - PIPE_CTRL_BUBBLE : default no-op control value (no mem access, no reg write)
//   - CTRL_*           : bit positions of the control field, so every stage
//                        packs and unpacks mem_read/mem_write/mask/reg_write/
//                        mem_to_reg the same way
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int         PIPE_CTRL_W      = 8;
    localparam logic [7:0] PIPE_CTRL_BUBBLE = 8'h00;

    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MASK_LSB   = 2;
    localparam int CTRL_MASK_W     = 2;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_TO_REG = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// Saturating up-counter used for performance counters.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears count
//   inc   : add one this cycle (ignored once count is all ones)
//   count : current value, sticks at 2^CNT_W-1
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a control field forced to CTRL_BUBBLE
// whenever the stage holds nothing.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   i_flush                : drop all held entries
//   i_in_valid/o_in_ready  : upstream handshake
//   i_in_data/i_in_ctrl    : upstream payload
//   o_out_valid/i_out_ready: downstream handshake
//   o_out_data/o_out_ctrl  : held payload (ctrl = CTRL_BUBBLE when not valid)
//   o_stall_cnt            : saturating count of cycles with valid & !ready
//
// state | meaning
// EMPTY | nothing held, output is a bubble
// ONE   | main entry holds the presented instruction
// TWO   | main and skid entries full, upstream stalled (SKID=1 only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE),
    parameter int                SKID        = 1,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_stall;

    assign w_out_valid = (r_state != EMPTY);

    // SKID=1 uses a registered ready (masked by rst so it is low during reset);
    // SKID=0 passes downstream ready straight through.
    assign w_in_ready = (SKID != 0) ? (r_in_ready & ~rst)
                                    : (~rst & (~w_out_valid | i_out_ready));

    assign w_in_fire  = i_in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & i_out_ready;
    assign w_stall    = w_out_valid & ~i_out_ready;

    // With SKID=0 the stage never sees an input fire alone in ONE, because
    // ready then requires out_ready; so TWO is unreachable in that mode.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ONE;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = TWO;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ONE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= CTRL_BUBBLE;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
            if (w_load_main_in) begin
                r_main_data <= i_in_data;
                r_main_ctrl <= i_in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end else if (w_state_nxt == EMPTY) begin
                // data is left as-is; only the control field goes to bubble
                r_main_ctrl <= CTRL_BUBBLE;
            end
        end
    end

    // Skid contents are only observable after a load, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_data <= i_in_data;
            r_skid_ctrl <= i_in_ctrl;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (o_stall_cnt)
    );

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = r_main_data;
    assign o_out_ctrl  = w_out_valid ? r_main_ctrl : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Three instances: A (SKID=1, 32-bit counter), B (SKID=0), C (SKID=1, 4-bit
// counter). Per-DUT scoreboards push {ctrl,data} on each input fire and pop on
// each output fire; scenario tasks check handshake timing and counters.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // DUT A
    logic        flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [63:0] in_data_a = '0;
    logic [7:0]  in_ctrl_a = '0;
    logic        in_ready_a, out_valid_a;
    logic [63:0] out_data_a;
    logic [7:0]  out_ctrl_a;
    logic [31:0] stall_a;

    // DUT B
    logic        flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [63:0] in_data_b = '0;
    logic [7:0]  in_ctrl_b = '0;
    logic        in_ready_b, out_valid_b;
    logic [63:0] out_data_b;
    logic [7:0]  out_ctrl_b;
    logic [31:0] stall_b;

    // DUT C
    logic        flush_c = 1'b0, in_valid_c = 1'b0, out_ready_c = 1'b0;
    logic [63:0] in_data_c = '0;
    logic [7:0]  in_ctrl_c = '0;
    logic        in_ready_c, out_valid_c;
    logic [63:0] out_data_c;
    logic [7:0]  out_ctrl_c;
    logic [3:0]  stall_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [71:0] sb_a[$];
    logic [71:0] sb_b[$];

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .i_flush(flush_a),
        .i_in_valid(in_valid_a), .o_in_ready(in_ready_a),
        .i_in_data(in_data_a), .i_in_ctrl(in_ctrl_a),
        .o_out_valid(out_valid_a), .i_out_ready(out_ready_a),
        .o_out_data(out_data_a), .o_out_ctrl(out_ctrl_a),
        .o_stall_cnt(stall_a)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .i_flush(flush_b),
        .i_in_valid(in_valid_b), .o_in_ready(in_ready_b),
        .i_in_data(in_data_b), .i_in_ctrl(in_ctrl_b),
        .o_out_valid(out_valid_b), .i_out_ready(out_ready_b),
        .o_out_data(out_data_b), .o_out_ctrl(out_ctrl_b),
        .o_stall_cnt(stall_b)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .i_flush(flush_c),
        .i_in_valid(in_valid_c), .o_in_ready(in_ready_c),
        .i_in_data(in_data_c), .i_in_ctrl(in_ctrl_c),
        .o_out_valid(out_valid_c), .i_out_ready(out_ready_c),
        .o_out_data(out_data_c), .o_out_ctrl(out_ctrl_c),
        .o_stall_cnt(stall_c)
    );

    // Scoreboard A: sampled at negedge, i.e. the values the next posedge sees.
    always @(negedge clk) begin
        logic [71:0] exp_a;
        if (rst !== 1'b1) begin
            if (flush_a) begin
                sb_a.delete();
            end else begin
                if (out_valid_a && out_ready_a) begin
                    n_tests++;
                    if (sb_a.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_a_extra: got %h expected nothing", {out_ctrl_a, out_data_a});
                    end else begin
                        exp_a = sb_a.pop_front();
                        if ({out_ctrl_a, out_data_a} !== exp_a) begin
                            n_fail++;
                            $display("FAIL sb_a_order: got %h expected %h", {out_ctrl_a, out_data_a}, exp_a);
                        end
                    end
                end
                if (in_valid_a && in_ready_a) sb_a.push_back({in_ctrl_a, in_data_a});
            end
        end
    end

    always @(negedge clk) begin
        logic [71:0] exp_b;
        if (rst !== 1'b1) begin
            if (flush_b) begin
                sb_b.delete();
            end else begin
                if (out_valid_b && out_ready_b) begin
                    n_tests++;
                    if (sb_b.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_b_extra: got %h expected nothing", {out_ctrl_b, out_data_b});
                    end else begin
                        exp_b = sb_b.pop_front();
                        if ({out_ctrl_b, out_data_b} !== exp_b) begin
                            n_fail++;
                            $display("FAIL sb_b_order: got %h expected %h", {out_ctrl_b, out_data_b}, exp_b);
                        end
                    end
                end
                if (in_valid_b && in_ready_b) sb_b.push_back({in_ctrl_b, in_data_b});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid_a = 1'b1; in_data_a = 64'hAB; in_ctrl_a = 8'h13;
        in_valid_b = 1'b1; in_data_b = 64'hAB; in_ctrl_b = 8'h13;
        @(negedge clk);
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid_a: got %b expected 0", out_valid_a); end
        n_tests++; if (out_ctrl_a !== 8'h00) begin n_fail++; $display("FAIL rst_out_ctrl_a: got %h expected 00", out_ctrl_a); end
        n_tests++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_a: got %b expected 0", in_ready_a); end
        n_tests++; if (in_ready_b !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_b: got %b expected 0", in_ready_b); end
        @(negedge clk);
        n_tests++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL rst2_in_ready_a: got %b expected 0", in_ready_a); end
        n_tests++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid_b: got %b expected 0", out_valid_b); end
        tick();
        rst = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        @(negedge clk);
        n_tests++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready_a: got %b expected 1", in_ready_a); end
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid_a: got %b expected 0", out_valid_a); end
        n_tests++; if (out_data_a !== 64'h0) begin n_fail++; $display("FAIL post_rst_out_data_a: got %h expected 0", out_data_a); end
        n_tests++; if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready_b: got %b expected 1", in_ready_b); end
        n_tests++; if (stall_b !== 32'd0) begin n_fail++; $display("FAIL post_rst_stall_b: got %0d expected 0", stall_b); end
        n_tests++; if (stall_c !== 4'd0) begin n_fail++; $display("FAIL post_rst_stall_c: got %0d expected 0", stall_c); end
        tick();
    endtask

    task automatic test_streaming;
        logic ev;
        out_ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid_a = 1'b1;
            in_data_a  = 64'(i);
            in_ctrl_a  = 8'h20 + 8'(i);
            ev = (i > 1);
            @(negedge clk);
            n_tests++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: got %b expected 1 (i=%0d)", in_ready_a, i); end
            n_tests++; if (out_valid_a !== ev) begin n_fail++; $display("FAIL stream_out_valid: got %b expected %b (i=%0d)", out_valid_a, ev, i); end
            if (i > 1) begin
                n_tests++;
                if (out_data_a !== 64'(i - 1)) begin n_fail++; $display("FAIL stream_latency: got %h expected %h", out_data_a, 64'(i - 1)); end
            end
            tick();
        end
        in_valid_a = 1'b0;
        @(negedge clk);
        n_tests++; if (out_data_a !== 64'h8) begin n_fail++; $display("FAIL stream_last: got %h expected 8", out_data_a); end
        tick();
        @(negedge clk);
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL stream_empty_valid: got %b expected 0", out_valid_a); end
        n_tests++; if (out_ctrl_a !== 8'h00) begin n_fail++; $display("FAIL stream_empty_ctrl: got %h expected 00", out_ctrl_a); end
        n_tests++; if (out_data_a !== 64'h8) begin n_fail++; $display("FAIL stream_data_retain: got %h expected 8", out_data_a); end
        n_tests++; if (stall_a !== 32'd0) begin n_fail++; $display("FAIL stream_stall: got %0d expected 0", stall_a); end
        tick();
    endtask

    task automatic test_backpressure;
        // per cycle: out_ready, in_valid, data, expected in_ready
        logic        rdy_tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        vld_tab[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  dat_tab[7]  = '{8'h10, 8'h11, 8'h12, 8'h12, 8'h12, 8'h12, 8'h00};
        logic        erdy_tab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 7; c++) begin
            out_ready_a = rdy_tab[c];
            in_valid_a  = vld_tab[c];
            in_data_a   = 64'(dat_tab[c]);
            in_ctrl_a   = dat_tab[c] + 8'h40;
            @(negedge clk);
            n_tests++;
            if (in_ready_a !== erdy_tab[c]) begin n_fail++; $display("FAIL bp_in_ready: got %b expected %b (cycle %0d)", in_ready_a, erdy_tab[c], c); end
            tick();
        end
        in_valid_a = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid_a); end
        n_tests++; if (stall_a !== 32'd3) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_a); end
        n_tests++; if (sb_a.size() != 0) begin n_fail++; $display("FAIL bp_lost_entries: got %0d expected 0", sb_a.size()); end
        tick();
    endtask

    task automatic test_flush;
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_data_a = 64'h20; in_ctrl_a = 8'h60;
        tick();
        in_data_a = 64'h21; in_ctrl_a = 8'h61;
        tick();
        flush_a = 1'b1; in_data_a = 64'h99; in_ctrl_a = 8'h69;
        @(negedge clk);
        n_tests++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL flush_two_ready: got %b expected 0", in_ready_a); end
        tick();
        flush_a = 1'b0; in_valid_a = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid_a); end
        n_tests++; if (out_ctrl_a !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 00", out_ctrl_a); end
        n_tests++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready_a); end
        n_tests++; if (stall_a !== 32'd5) begin n_fail++; $display("FAIL flush_keeps_stall: got %0d expected 5", stall_a); end
        tick();
        in_valid_a = 1'b1; in_data_a = 64'h30; in_ctrl_a = 8'h70;
        tick();
        flush_a = 1'b1; in_data_a = 64'h98; in_ctrl_a = 8'h78;
        @(negedge clk);
        n_tests++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_one_ready: got %b expected 1", in_ready_a); end
        tick();
        flush_a = 1'b0; in_data_a = 64'h31; in_ctrl_a = 8'h71; out_ready_a = 1'b1;
        @(negedge clk);
        n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_drop_input: got %b expected 0", out_valid_a); end
        tick();
        in_valid_a = 1'b0;
        @(negedge clk);
        n_tests++; if (out_data_a !== 64'h31) begin n_fail++; $display("FAIL flush_resume: got %h expected 31", out_data_a); end
        tick();
        @(negedge clk);
        n_tests++; if (stall_a !== 32'd6) begin n_fail++; $display("FAIL flush_stall_total: got %0d expected 6", stall_a); end
        n_tests++; if (sb_a.size() != 0) begin n_fail++; $display("FAIL flush_sb_left: got %0d expected 0", sb_a.size()); end
        tick();
    endtask

    task automatic test_skid0;
        logic mv;
        logic er;
        int   idx;
        mv  = 1'b0;
        idx = 0;
        for (int j = 0; j < 8; j++) begin
            in_valid_b  = 1'b1;
            in_data_b   = 64'h40 + 64'(idx);
            in_ctrl_b   = 8'h70 + 8'(idx);
            out_ready_b = (j % 2 == 0);
            er = !mv || out_ready_b;
            @(negedge clk);
            n_tests++; if (in_ready_b !== er) begin n_fail++; $display("FAIL s0_in_ready: got %b expected %b (j=%0d)", in_ready_b, er, j); end
            n_tests++; if (out_valid_b !== mv) begin n_fail++; $display("FAIL s0_out_valid: got %b expected %b (j=%0d)", out_valid_b, mv, j); end
            if (er) begin
                mv = 1'b1;
                idx++;
            end else if (mv && out_ready_b) begin
                mv = 1'b0;
            end
            tick();
        end
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        tick();
        @(negedge clk);
        n_tests++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL s0_drained: got %b expected 0", out_valid_b); end
        n_tests++; if (sb_b.size() != 0) begin n_fail++; $display("FAIL s0_sb_left: got %0d expected 0", sb_b.size()); end
        tick();
    endtask

    task automatic test_saturation;
        logic [3:0] es;
        in_valid_c = 1'b1; in_data_c = 64'h55; in_ctrl_c = 8'h11; out_ready_c = 1'b0;
        tick();
        in_valid_c = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            es = (j - 1 > 15) ? 4'd15 : 4'(j - 1);
            @(negedge clk);
            n_tests++; if (out_valid_c !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b expected 1 (j=%0d)", out_valid_c, j); end
            n_tests++; if (stall_c !== es) begin n_fail++; $display("FAIL sat_cnt: got %0d expected %0d (j=%0d)", stall_c, es, j); end
            tick();
        end
        out_ready_c = 1'b1;
        @(negedge clk);
        n_tests++; if (stall_c !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", stall_c); end
        tick();
        @(negedge clk);
        n_tests++; if (out_ctrl_c !== 8'h00) begin n_fail++; $display("FAIL sat_empty_ctrl: got %h expected 00", out_ctrl_c); end
        n_tests++; if (out_data_c !== 64'h55) begin n_fail++; $display("FAIL sat_data_retain: got %h expected 55", out_data_c); end
        n_tests++; if (in_ready_c !== 1'b1) begin n_fail++; $display("FAIL sat_in_ready: got %b expected 1", in_ready_c); end
        n_tests++; if (stall_c !== 4'd15) begin n_fail++; $display("FAIL sat_no_wrap: got %0d expected 15", stall_c); end
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid0();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
